// File: rtl/logdrop_accum_pkg.sv
// Shared types and helpers for the logarithmic-drop window accumulator.
package logdrop_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } stateT;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/logdrop_accum_if.sv
// Sample-in / sum-out stream bundle for logdrop_accum; master is the driving side.
interface logdrop_accum_if
  import logdrop_accum_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned WINLEN = 64
);

  localparam int unsigned SUM_W = DATA_W + clog2(clog2(WINLEN) + 1);

  logic              i_cg;
  logic              i_start;
  logic [DATA_W-1:0] i_x;
  logic              i_valid;
  logic              o_ready;
  logic [SUM_W-1:0]  o_sum;
  logic              o_valid;
  logic              i_ready;
  logic              o_busy;

  modport master (
    output i_cg, i_start, i_x, i_valid, i_ready,
    input  o_ready, o_sum, o_valid, o_busy
  );

  modport slave (
    input  i_cg, i_start, i_x, i_valid, i_ready,
    output o_ready, o_sum, o_valid, o_busy
  );

endinterface

// File: rtl/logdrop_accum_window.sv
// Logarithmic-drop window: w = x >> floor(log2(t+1)), zero-extended to SUM_W.
module logdropWindow
  import logdrop_accum_pkg::*;
#(
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned WINLEN = 64,
  localparam int unsigned TW     = clog2(WINLEN),
  localparam int unsigned SUM_W  = DATA_W + clog2(clog2(WINLEN) + 1)
) (
  input  logic [TW-1:0]     t,
  input  logic [DATA_W-1:0] x,
  output logic [SUM_W-1:0]  w
);

  localparam int unsigned SHW = clog2(TW + 1);

  logic [TW:0]    tPlus1;
  logic [SHW-1:0] shift;

  // Highest set bit of t+1 is floor(log2(t+1)).
  always_comb begin
    tPlus1 = {1'b0, t} + (TW + 1)'(1);
    shift  = '0;
    for (int unsigned i = 0; i <= TW; i++) begin
      if (tPlus1[i]) shift = SHW'(i);
    end
    w = SUM_W'(x) >> shift;
  end

endmodule

// File: rtl/logdrop_accum.sv
// Accumulates one window of WINLEN log-drop-weighted samples and presents the sum.
module logdrop_accum
  import logdrop_accum_pkg::*;
#(
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned WINLEN = 64,
  localparam int unsigned TW     = clog2(WINLEN),
  localparam int unsigned SUM_W  = DATA_W + clog2(clog2(WINLEN) + 1)
) (
  input logic            i_clk,
  input logic            i_rst,
  logdrop_accum_if.slave bus
);

  stateT            state;
  stateT            nextState;
  logic [TW-1:0]    t;
  logic [SUM_W-1:0] acc;
  logic [SUM_W-1:0] sumQ;
  logic [SUM_W-1:0] w;
  logic             lastT;
  logic             accept;
  logic             restart;

  logdropWindow #(
    .DATA_W (DATA_W),
    .WINLEN (WINLEN)
  ) uWindow (
    .t (t),
    .x (bus.i_x),
    .w (w)
  );

  assign lastT   = (t == TW'(WINLEN - 1));
  assign accept  = bus.i_cg && (state == ACCUM) && bus.i_valid;
  assign restart = bus.i_cg && bus.i_start &&
                   ((state == IDLE) || ((state == DONE) && bus.i_ready));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else if (bus.i_cg) begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (bus.i_start) nextState = ACCUM;
      ACCUM:   if (bus.i_valid && lastT) nextState = DONE;
      DONE:    if (bus.i_ready) nextState = bus.i_start ? ACCUM : IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Final sum is captured on the last accept so it is valid together with DONE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      t    <= '0;
      acc  <= '0;
      sumQ <= '0;
    end else if (restart) begin
      t   <= '0;
      acc <= '0;
    end else if (accept) begin
      t   <= t + TW'(1);
      acc <= acc + w;
      if (lastT) sumQ <= acc + w;
    end
  end

  always_comb begin
    bus.o_ready = (state == ACCUM);
    bus.o_valid = (state == DONE);
    bus.o_busy  = (state != IDLE);
    bus.o_sum   = sumQ;
  end

endmodule

// File: tb/tb_logdrop_accum.sv
// Scoreboard bench for logdrop_accum: default 64-sample window plus a 16-sample, 5-bit instance.
module tb_logdrop_accum;

  logic clk;
  logic rst;

  int checks;
  int errors;
  int unsigned expQ[$];

  logdrop_accum_if #(.DATA_W(8), .WINLEN(64)) busA ();
  logdrop_accum_if #(.DATA_W(5), .WINLEN(16)) busB ();

  logdrop_accum #(.DATA_W(8), .WINLEN(64)) dutA (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (busA.slave)
  );

  logdrop_accum #(.DATA_W(5), .WINLEN(16)) dutB (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (busB.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  function automatic int unsigned modelSum(input int unsigned x, input int unsigned winLen);
    int unsigned s;
    int unsigned k;
    int unsigned sum;
    sum = 0;
    for (int unsigned ti = 0; ti < winLen; ti++) begin
      s = 0;
      k = ti + 1;
      while (k > 1) begin
        k = k >> 1;
        s++;
      end
      sum += x >> s;
    end
    return sum;
  endfunction

  task automatic startA();
    busA.i_start = 1'b1;
    @(negedge clk);
    busA.i_start = 1'b0;
  endtask

  task automatic handshakeA();
    busA.i_ready = 1'b1;
    @(negedge clk);
    busA.i_ready = 1'b0;
  endtask

  // Feeds n accepted samples; counts ready-low and early-valid cycles seen while feeding.
  task automatic feedA(input logic [7:0] x, input int n, input bit randValid,
                       output int readyLow, output int earlyValid, output bit timedOut);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    readyLow = 0;
    earlyValid = 0;
    timedOut = 1'b0;
    while (got < n) begin
      if (cyc > 2000) begin
        timedOut = 1'b1;
        break;
      end
      cyc++;
      busA.i_x = x;
      busA.i_valid = randValid ? 1'($urandom_range(0, 1)) : 1'b1;
      if (busA.o_ready !== 1'b1) readyLow++;
      if (busA.o_valid !== 1'b0) earlyValid++;
      if (busA.i_valid && busA.o_ready) got++;
      @(negedge clk);
    end
    busA.i_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    busA.i_cg = 1'b1; busA.i_start = 1'b0; busA.i_x = '0; busA.i_valid = 1'b0; busA.i_ready = 1'b0;
    busB.i_cg = 1'b1; busB.i_start = 1'b0; busB.i_x = '0; busB.i_valid = 1'b0; busB.i_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busA.o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", busA.o_ready); end
    checks++;
    if (busA.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", busA.o_valid); end
    checks++;
    if (busA.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busA.o_busy); end
    checks++;
    if (busA.o_sum !== 11'd0) begin errors++; $display("FAIL reset_sum: got %0d want 0", busA.o_sum); end
    checks++;
    if ({busB.o_ready, busB.o_valid, busB.o_busy} !== 3'b000 || busB.o_sum !== 8'd0) begin
      errors++; $display("FAIL reset_small: got rvb=%b%b%b sum=%0d want 000 sum=0",
                         busB.o_ready, busB.o_valid, busB.o_busy, busB.o_sum);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_scale();
    int rl, ev;
    bit to;
    int unsigned expSum;
    startA();
    expQ.push_back(modelSum(255, 64));
    checks++;
    if (busA.o_ready !== 1'b1 || busA.o_busy !== 1'b1) begin
      errors++; $display("FAIL full_enter_accum: ready=%b busy=%b want 1 1", busA.o_ready, busA.o_busy);
    end
    feedA(8'd255, 64, 1'b0, rl, ev, to);
    checks++;
    if (to || ev != 0) begin errors++; $display("FAIL full_feed: timeout=%0d earlyValid=%0d want 0 0", to, ev); end
    checks++;
    if (busA.o_valid !== 1'b1 || busA.o_ready !== 1'b0) begin
      errors++; $display("FAIL full_latency: valid=%b ready=%b want 1 0 one cycle after last accept",
                         busA.o_valid, busA.o_ready);
    end
    expSum = expQ.pop_front();
    checks++;
    if (busA.o_sum !== 11'(expSum)) begin errors++; $display("FAIL full_sum: got %0d want %0d", busA.o_sum, expSum); end
    handshakeA();
    checks++;
    if (busA.o_valid !== 1'b0 || busA.o_busy !== 1'b0 || busA.o_sum !== 11'(expSum)) begin
      errors++; $display("FAIL full_idle: valid=%b busy=%b sum=%0d want 0 0 %0d",
                         busA.o_valid, busA.o_busy, busA.o_sum, expSum);
    end
  endtask

  task automatic test_random_valid();
    int rl, ev;
    bit to;
    int unsigned expSum;
    startA();
    expQ.push_back(modelSum(64, 64));
    feedA(8'd64, 64, 1'b1, rl, ev, to);
    checks++;
    if (to || rl != 0 || ev != 0) begin
      errors++; $display("FAIL rand_feed: timeout=%0d readyLow=%0d earlyValid=%0d want 0 0 0", to, rl, ev);
    end
    checks++;
    if (busA.o_valid !== 1'b1) begin errors++; $display("FAIL rand_valid: got %b want 1", busA.o_valid); end
    expSum = expQ.pop_front();
    checks++;
    if (busA.o_sum !== 11'(expSum)) begin errors++; $display("FAIL rand_sum: got %0d want %0d", busA.o_sum, expSum); end
    handshakeA();
  endtask

  task automatic test_hold_output();
    int rl, ev;
    bit to;
    int unsigned expSum;
    startA();
    expQ.push_back(modelSum(1, 64));
    feedA(8'd1, 64, 1'b0, rl, ev, to);
    checks++;
    if (to || busA.o_valid !== 1'b1) begin
      errors++; $display("FAIL hold_valid: timeout=%0d valid=%b want 0 1", to, busA.o_valid);
    end
    expSum = expQ.pop_front();
    busA.i_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      busA.i_start = (c == 2 || c == 6) ? 1'b1 : 1'b0;
      @(negedge clk);
      checks++;
      if (busA.o_valid !== 1'b1 || busA.o_sum !== 11'(expSum) || busA.o_ready !== 1'b0) begin
        errors++; $display("FAIL hold_stable[%0d]: valid=%b ready=%b sum=%0d want 1 0 %0d",
                           c, busA.o_valid, busA.o_ready, busA.o_sum, expSum);
      end
    end
    busA.i_start = 1'b0;
    handshakeA();
    checks++;
    if (busA.o_busy !== 1'b0 || busA.o_sum !== 11'(expSum)) begin
      errors++; $display("FAIL hold_release: busy=%b sum=%0d want 0 %0d", busA.o_busy, busA.o_sum, expSum);
    end
  endtask

  task automatic test_back_to_back();
    int rl, ev;
    bit to;
    int unsigned expSum;
    startA();
    expQ.push_back(modelSum(255, 64));
    feedA(8'd255, 64, 1'b0, rl, ev, to);
    expSum = expQ.pop_front();
    checks++;
    if (to || busA.o_valid !== 1'b1 || busA.o_sum !== 11'(expSum)) begin
      errors++; $display("FAIL b2b_first: timeout=%0d valid=%b sum=%0d want 0 1 %0d", to, busA.o_valid, busA.o_sum, expSum);
    end
    busA.i_ready = 1'b1;
    busA.i_start = 1'b1;
    expQ.push_back(modelSum(255, 64));
    @(negedge clk);
    busA.i_ready = 1'b0;
    busA.i_start = 1'b0;
    checks++;
    if (busA.o_ready !== 1'b1 || busA.o_valid !== 1'b0 || busA.o_busy !== 1'b1) begin
      errors++; $display("FAIL b2b_no_idle: ready=%b valid=%b busy=%b want 1 0 1", busA.o_ready, busA.o_valid, busA.o_busy);
    end
    feedA(8'd255, 64, 1'b0, rl, ev, to);
    expSum = expQ.pop_front();
    checks++;
    if (to || busA.o_valid !== 1'b1 || busA.o_sum !== 11'(expSum)) begin
      errors++; $display("FAIL b2b_second: timeout=%0d valid=%b sum=%0d want 0 1 %0d", to, busA.o_valid, busA.o_sum, expSum);
    end
    handshakeA();
  endtask

  task automatic test_abort_reset();
    int rl, ev;
    bit to;
    int unsigned expSum;
    startA();
    feedA(8'd255, 30, 1'b0, rl, ev, to);
    busA.i_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busA.o_ready, busA.o_valid, busA.o_busy} !== 3'b000 || busA.o_sum !== 11'd0) begin
      errors++; $display("FAIL abort_async: rvb=%b%b%b sum=%0d want 000 sum=0",
                         busA.o_ready, busA.o_valid, busA.o_busy, busA.o_sum);
    end
    busA.i_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    startA();
    expQ.push_back(modelSum(64, 64));
    feedA(8'd64, 64, 1'b0, rl, ev, to);
    expSum = expQ.pop_front();
    checks++;
    if (to || busA.o_valid !== 1'b1 || busA.o_sum !== 11'(expSum)) begin
      errors++; $display("FAIL abort_fresh: timeout=%0d valid=%b sum=%0d want 0 1 %0d", to, busA.o_valid, busA.o_sum, expSum);
    end
    handshakeA();
  endtask

  task automatic test_small_window_cg();
    int got, cyc, gated, ev;
    int unsigned expSum;
    busB.i_start = 1'b1;
    @(negedge clk);
    busB.i_start = 1'b0;
    expQ.push_back(modelSum(31, 16));
    got = 0; cyc = 0; gated = 0; ev = 0;
    while (got < 16 && cyc < 500) begin
      cyc++;
      busB.i_x = 5'd31;
      busB.i_valid = 1'b1;
      if (busB.o_valid !== 1'b0) ev++;
      if (got == 5 && gated < 5) begin
        busB.i_cg = 1'b0;
        gated++;
        checks++;
        if (busB.o_ready !== 1'b1 || busB.o_busy !== 1'b1) begin
          errors++; $display("FAIL cg_comb_outputs[%0d]: ready=%b busy=%b want 1 1", gated, busB.o_ready, busB.o_busy);
        end
      end else begin
        busB.i_cg = 1'b1;
        if (busB.i_valid && busB.o_ready) got++;
      end
      @(negedge clk);
    end
    busB.i_valid = 1'b0;
    busB.i_cg = 1'b1;
    checks++;
    if (cyc >= 500 || ev != 0) begin
      errors++; $display("FAIL cg_feed: cycles=%0d earlyValid=%0d want <500 0", cyc, ev);
    end
    expSum = expQ.pop_front();
    checks++;
    if (busB.o_valid !== 1'b1 || busB.o_sum !== 8'(expSum)) begin
      errors++; $display("FAIL cg_sum: valid=%b sum=%0d want 1 %0d", busB.o_valid, busB.o_sum, expSum);
    end
    busB.i_ready = 1'b1;
    @(negedge clk);
    busB.i_ready = 1'b0;
    checks++;
    if (busB.o_busy !== 1'b0) begin errors++; $display("FAIL cg_idle: busy=%b want 0", busB.o_busy); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    test_reset();
    test_full_scale();
    test_random_valid();
    test_hold_output();
    test_back_to_back();
    test_abort_reset();
    test_small_window_cg();
    checks++;
    if (expQ.size() != 0) begin errors++; $display("FAIL scoreboard_empty: %0d left want 0", expQ.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
